// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: FETCH -> WAIT -> DECODE -> EXECUTE, one execute strobe per word.
// Optional WAIT timeout with a sticky fault flag is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        execute,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DECODE  = 2'd2,
    S_EXECUTE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        fault_q, fault_d;

  // Counts busy WAIT cycles; the last allowed busy cycle converts the fetch into a NOP.
  assign timeout_hit = (state_q == S_WAIT) && mem_rbusy && (tmo_q == TIMEOUT_CYCLES - 32'd1);

  always_comb begin
    tmo_d   = tmo_q;
    fault_d = fault_q;
    if (state_q == S_FETCH) begin
      tmo_d = '0;
    end else if ((state_q == S_WAIT) && mem_rbusy) begin
      tmo_d = tmo_q + 32'd1;
    end
    if (timeout_hit) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tmo_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  assign timeout_hit = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_WAIT;
      S_WAIT:    if (!mem_rbusy || timeout_hit) state_d = S_DECODE;
      S_DECODE:  if (!stall) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  // Masking keeps the redirect target word aligned regardless of its low bits.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (state_q == S_WAIT) begin
      if (!mem_rbusy) begin
        instr_d = mem_rdata;
      end else if (timeout_hit) begin
        instr_d = NOP_INSTR;
      end
    end
    if (state_q == S_EXECUTE) begin
      pc_d = redirect ? (redirect_pc & 32'hFFFF_FFFC) : (pc_q + 32'd4);
    end
  end

  always_comb begin
    mem_rstrb   = resetn && (state_q == S_FETCH);
    execute     = (state_q == S_EXECUTE);
    mem_addr    = pc_q;
    pc          = pc_q;
    instruction = instr_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected fetches/executes,
// monitors on the falling edge pop and compare.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          TMO    = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_rbusy = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        execute;
  logic        fetch_fault;

  instr_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_rbusy(mem_rbusy), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .instruction(instruction), .execute(execute),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          lat;
    logic        fault;
  } exec_t;

  logic [31:0] fq[$];
  exec_t       eq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          rstrb_cyc = 0;
  bit          chk_en = 1'b0;
  int          busy_cfg = 0;
  logic [31:0] cur_word = 32'h0;
  logic        exp_fault = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: busy for busy_cfg WAIT cycles after each strobe, junk data while busy.
  initial begin
    int wcnt = 0;
    forever begin
      @(negedge clk);
      if (mem_rstrb) wcnt = 0;
      else if (wcnt < 100000) wcnt++;
      mem_rbusy = (wcnt >= 1) && (wcnt <= busy_cfg);
      mem_rdata = mem_rbusy ? 32'hDEAD_BEEF : cur_word;
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (mem_rstrb) begin
          rstrb_cyc = cyc;
          if (fq.size() == 0) begin
            chk("stray_rstrb", 32'd1, 32'd0);
          end else begin
            logic [31:0] ea;
            ea = fq.pop_front();
            chk("fetch_addr", mem_addr, ea);
          end
        end
        if (execute) begin
          if (eq.size() == 0) begin
            chk("stray_execute", 32'd1, 32'd0);
          end else begin
            exec_t e;
            e = eq.pop_front();
            chk("exec_pc", pc, e.pc);
            chk("exec_instr", instruction, e.instr);
            chk("exec_latency", 32'(cyc - rstrb_cyc), 32'(e.lat));
            chk("exec_fault", {31'd0, fetch_fault}, {31'd0, e.fault});
          end
        end
      end
    end
  end

  // One instruction; returns on the falling edge of its EXECUTE cycle so the next call
  // must see the strobe on its very first falling edge.
  // rmode: 0 no redirect, 1 redirect held throughout, 2 redirect everywhere except EXECUTE.
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] exp_instr, input int busy, input int lat_busy,
                           input int stall_n, input int rmode, input logic [31:0] rpc);
    int L;
    exec_t e;
    L = lat_busy + 3 + stall_n;
    busy_cfg = busy;
    cur_word = word;
    fq.push_back(addr);
    e.pc = addr; e.instr = exp_instr; e.lat = L; e.fault = exp_fault;
    eq.push_back(e);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      if (k == 0) chk("rstrb_on_time", {31'd0, mem_rstrb}, 32'd1);
      stall       = (k < lat_busy + 2 + stall_n);
      redirect    = (rmode == 1) || ((rmode == 2) && (k != L));
      redirect_pc = rpc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instruction, NOP);
    chk("rst_execute", {31'd0, execute}, 32'd0);
    chk("rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk_en = 1'b1;
    @(posedge clk); #1 resetn = 1'b1;

    run_instr(32'h0000_0000, 32'h0050_0093, 32'h0050_0093, 0, 0, 0, 0, 32'h0);
    run_instr(32'h0000_0004, 32'h00A0_0113, 32'h00A0_0113, 5, 5, 0, 0, 32'h0);
    run_instr(32'h0000_0008, 32'h0000_0193, 32'h0000_0193, 0, 0, 0, 1, 32'h0000_0103);
    run_instr(32'h0000_0100, 32'h0020_8233, 32'h0020_8233, 0, 0, 0, 2, 32'h0000_0200);
    run_instr(32'h0000_0104, 32'h1234_5678, 32'h1234_5678, 1, 1, 3, 1, 32'hFFFF_FFFF);
    run_instr(32'hFFFF_FFFC, 32'h0FF0_0293, 32'h0FF0_0293, 2, 2, 0, 0, 32'h0);
    run_instr(32'h0000_0000, 32'h1111_1111, 32'h1111_1111, 0, 0, 0, 0, 32'h0);

    // Abort a fetch in WAIT with reset; its execute must never appear.
    busy_cfg = 1000;
    fq.push_back(32'h0000_0004);
    @(negedge clk);
    chk("rstrb_before_abort", {31'd0, mem_rstrb}, 32'd1);
    @(posedge clk); #1 resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pc", pc, RST_PC);
    chk("abort_instr", instruction, NOP);
    chk("abort_execute", {31'd0, execute}, 32'd0);
    chk("abort_rstrb", {31'd0, mem_rstrb}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    run_instr(RST_PC, 32'h0030_0313, 32'h0030_0313, 0, 0, 0, 0, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    exp_fault = 1'b1;
    run_instr(32'h0000_0004, 32'h7777_7777, NOP, 1000, TMO - 1, 0, 0, 32'h0);
    run_instr(32'h0000_0008, 32'h0040_0393, 32'h0040_0393, 0, 0, 0, 0, 32'h0);
`else
    chk("fault_tied_low", {31'd0, fetch_fault}, 32'd0);
`endif

    @(posedge clk); #1 chk_en = 1'b0;
    chk("fetch_queue_empty", 32'(fq.size()), 32'd0);
    chk("exec_queue_empty", 32'(eq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
